// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: functional-unit encoding, default
// outstanding-operation depths and a register-address decode helper.
package issue_scoreboard_pkg;

  typedef enum logic [2:0] {
    LU_ALU = 3'd0,
    LU_MUL = 3'd1,
    LU_MAC = 3'd2,
    LU_DIV = 3'd3,
    LU_LSU = 3'd4
  } lu_unit_t;

  localparam int DEF_MUL_DEPTH = 3;
  localparam int DEF_MAC_DEPTH = 3;
  localparam int DEF_DIV_DEPTH = 1;
  localparam int DEF_LSU_DEPTH = 1;
  localparam int NUM_LL_UNITS  = 4;

  function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
    reg_onehot = 32'd1 << addr;
  endfunction

endpackage

// File: rtl/issue_scoreboard_unit_occ_counter.sv
// Outstanding-operation counter for one long-latency unit; saturates at zero
// and flags writebacks that arrive with nothing outstanding.
module unit_occ_counter
  import issue_scoreboard_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_underflow,
  output logic o_busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] r_count;

  // Occupancy: simultaneous issue and writeback cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + CW'(1);
    end else if (!i_inc && i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_underflow = i_dec && (r_count == '0);
  assign o_busy      = (r_count != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: tracks registers awaiting long-latency writeback,
// stalls RAW/WAW hazards and full units, and counts in-flight operations.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MUL_DEPTH = DEF_MUL_DEPTH,
  parameter int MAC_DEPTH = DEF_MAC_DEPTH,
  parameter int DIV_DEPTH = DEF_DIV_DEPTH,
  parameter int LSU_DEPTH = DEF_LSU_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [2:0]  issue_unit,
  input  logic [4:0]  issue_rd_addr,
  input  logic        issue_rd,
  input  logic [4:0]  issue_rs1_addr,
  input  logic        issue_rs1,
  input  logic [4:0]  issue_rs2_addr,
  input  logic        issue_rs2,
  input  logic        pipe_flush,
  input  logic        wb_valid,
  input  logic [2:0]  wb_unit,
  input  logic [4:0]  wb_rd_addr,
  output logic        issue_stall,
  output logic        issue_accept,
  output logic [31:0] pending_mask,
  output logic [3:0]  unit_busy,
  output logic        sb_err
);

  logic [31:0] r_pending;
  logic        r_sb_err;
  logic [31:0] w_clr, w_eff, w_set;
  logic [NUM_LL_UNITS-1:0] w_tgt, w_wbu, w_full, w_uf, w_busy;
  logic w_raw, w_waw, w_struct, w_long, w_stall, w_accept;

  // Index u covers MUL, MAC, DIV, LSU, i.e. unit codes 1..4.
  for (genvar u = 0; u < NUM_LL_UNITS; u++) begin : g_unit
    localparam int DEP = (u == 0) ? MUL_DEPTH :
                         (u == 1) ? MAC_DEPTH :
                         (u == 2) ? DIV_DEPTH : LSU_DEPTH;

    assign w_tgt[u] = (issue_unit == 3'(u + 1));
    assign w_wbu[u] = wb_valid && (wb_unit == 3'(u + 1));

    unit_occ_counter #(.DEPTH(DEP)) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_inc       (w_accept && w_tgt[u]),
      .i_dec       (w_wbu[u]),
      .o_full      (w_full[u]),
      .o_underflow (w_uf[u]),
      .o_busy      (w_busy[u])
    );
  end

  // A writeback landing this cycle already satisfies a waiting reader.
  assign w_clr    = wb_valid ? reg_onehot(wb_rd_addr) : 32'd0;
  assign w_eff    = r_pending & ~w_clr;

  assign w_raw    = (issue_rs1 && (issue_rs1_addr != 5'd0) && w_eff[issue_rs1_addr]) ||
                    (issue_rs2 && (issue_rs2_addr != 5'd0) && w_eff[issue_rs2_addr]);
  assign w_waw    = issue_rd && (issue_rd_addr != 5'd0) && w_eff[issue_rd_addr];
  assign w_struct = |(w_tgt & w_full & ~w_wbu);
  assign w_stall  = issue_valid && (w_raw || w_waw || w_struct);
  assign w_accept = issue_valid && !w_stall && !pipe_flush;
  assign w_long   = |w_tgt;
  assign w_set    = (w_accept && w_long && issue_rd && (issue_rd_addr != 5'd0)) ?
                    reg_onehot(issue_rd_addr) : 32'd0;

  // Pending set wins over a clear of the same register; x0 never pends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & 32'hFFFF_FFFE;
    end
  end

  // Sticky until reset: any writeback to a unit with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else begin
      r_sb_err <= r_sb_err | (|w_uf);
    end
  end

  assign issue_stall  = w_stall;
  assign issue_accept = w_accept;
  assign pending_mask = r_pending;
  assign unit_busy    = w_busy;
  assign sb_err       = r_sb_err;

endmodule
